// File: rtl/host_cmd_seq.sv
// Host-side command sequencer: sends a 24-bit command as three UART bytes
// (MSB first) and collects the response stream, with NAK and timeout reporting.
module host_cmd_seq #(
  parameter int          DUMP_LEN  = 510,
  parameter int          TO_CYCLES = 1048576,
  parameter logic [7:0]  ACK_VAL   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cmd,
  input  logic        send_cmd,
  output logic        busy,
  output logic        cmd_sent,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        resp_last,
  output logic        nak_err,
  output logic        timeout_err
);

  localparam int              TO_W     = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYCLES - 1);
  localparam logic [12:0]     DUMP_REM = 13'(DUMP_LEN);

  typedef enum logic [2:0] {IDLE, LOAD, STRB, TX_WAIT, RX_WAIT, RX_GAP} state_t;

  state_t          state;
  logic [23:0]     cmd_reg;
  logic [1:0]      idx;
  logic [12:0]     remaining;
  logic [TO_W-1:0] to_cnt;
  logic            tx_done_q;
  logic            tx_rise;

  // Data-returning opcodes are exempt from the ACK check; anything else is ack-type.
  function automatic logic is_ack_type(input logic [7:0] op);
    return !(op == 8'h01 || op == 8'h07 || op == 8'h09);
  endfunction

  assign tx_rise = tx_done & ~tx_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_reg     <= '0;
      idx         <= '0;
      remaining   <= '0;
      to_cnt      <= '0;
      tx_done_q   <= 1'b0;
      busy        <= 1'b0;
      cmd_sent    <= 1'b0;
      tx_data     <= '0;
      trmt        <= 1'b0;
      clr_rx_rdy  <= 1'b0;
      resp        <= '0;
      resp_vld    <= 1'b0;
      resp_last   <= 1'b0;
      nak_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      trmt        <= 1'b0;
      cmd_sent    <= 1'b0;
      clr_rx_rdy  <= 1'b0;
      resp_vld    <= 1'b0;
      resp_last   <= 1'b0;
      nak_err     <= 1'b0;
      timeout_err <= 1'b0;
      tx_done_q   <= tx_done;
      case (state)
        IDLE: begin
          if (send_cmd) begin
            cmd_reg <= cmd;
            busy    <= 1'b1;
            idx     <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          tx_data <= (idx == 2'd0) ? cmd_reg[23:16] :
                     (idx == 2'd1) ? cmd_reg[15:8]  : cmd_reg[7:0];
          state   <= STRB;
        end
        // trmt trails tx_data by a cycle so the transmitter always latches a settled byte
        STRB: begin
          trmt  <= 1'b1;
          state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_rise) begin
            if (idx != 2'd2) begin
              idx   <= idx + 2'd1;
              state <= LOAD;
            end else begin
              cmd_sent  <= 1'b1;
              remaining <= (cmd_reg[23:16] == 8'h01) ? DUMP_REM : 13'd1;
              to_cnt    <= '0;
              state     <= RX_WAIT;
            end
          end
        end
        RX_WAIT: begin
          if (rx_rdy) begin
            resp       <= rx_data;
            resp_vld   <= 1'b1;
            clr_rx_rdy <= 1'b1;
            resp_last  <= (remaining == 13'd1);
            nak_err    <= is_ack_type(cmd_reg[23:16]) && (rx_data != ACK_VAL);
            remaining  <= remaining - 13'd1;
            to_cnt     <= '0;
            state      <= RX_GAP;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // rx_rdy is still high here because the clear lands a cycle late
        RX_GAP: begin
          if (remaining != 13'd0) begin
            state <= RX_WAIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
